paralelo_serial_param: RTL and testbench
========================================

// Module: paralelo_serial_param
// PURPOSE
//  Parametrised single-clock parallel-to-serial lane transmitter for the PCIe PHY TX path.
//  Accepts WIDTH-bit words per lane via valid/ready into a one-word holding register.
//  Shifts them out on the bit clock, all lanes in lockstep.
//  Sends SYNC_COUNT idle words after reset, then fills any data gap with IDLE_WORD.
// PARAMETERS
//  WIDTH       8       bits per symbol per lane
//  LANES       1       number of serial lanes; lane k uses data_in[k*WIDTH +: WIDTH]
//  MSB_FIRST   1       1: bit WIDTH-1 sent first; 0: bit 0 sent first
//  IDLE_WORD   8'hBC   symbol inserted during sync and when no data is held (WIDTH bits)
//  SYNC_COUNT  4       idle words sent after reset before ready_out may assert (>=1)
// PORTS
//  clk_32f      in   1            bit clock; all logic on its rising edge
//  reset        in   1            asynchronous, active-low
//  data_in      in   WIDTH*LANES  parallel words, one per lane
//  valid_in     in   1            data_in valid; word is taken when valid_in && ready_out
//  ready_out    out  1            holding register can take a word this cycle
//  data_out     out  LANES        serial bits, = shifter bit currently selected by MSB_FIRST
//  frame_start  out  1            high during the first bit of every word on data_out
//  idle_out     out  1            high while the word being shifted is an inserted IDLE_WORD
// BEHAVIOUR
//  Reset (reset=0, asynchronous): state=S_RESET; shifter, hold, cnt, sync_cnt cleared; hold_full=0.
//   All outputs are 0 while reset=0. A held word is discarded, never sent.
//  Counters: bit counter cnt in 0..WIDTH-1, shared by all lanes. boundary = (cnt==WIDTH-1).
//  FSM:
//   S_RESET : 1st edge with reset=1 loads IDLE_WORD into all lanes; cnt=0; sync_cnt=0; -> S_SYNC.
//   S_SYNC  : shift; at each boundary load IDLE_WORD and increment sync_cnt.
//             At the boundary where sync_cnt==SYNC_COUNT-1 -> S_ACTIVE.
//             The load at that edge uses the S_ACTIVE rule (hold is empty, so IDLE_WORD).
//   S_ACTIVE: shift; at each boundary load hold (hold_full<=0) if hold_full, else load IDLE_WORD.
//  Shift: on non-boundary edges cnt++ and each lane shifter shifts toward its output bit.
//   On a boundary edge cnt<=0 and the new word is loaded.
//  ready_out = (state==S_ACTIVE) && (!hold_full || boundary). It is combinational.
//  Accept: valid_in && ready_out at an edge writes data_in to hold and sets hold_full=1.
//   On the same edge, a boundary may move the old hold word into the shifter.
//  Data accepted on any edge is first sent after the next boundary edge strictly after it.
//   Worst-case latency is WIDTH cycles; a word accepted on a boundary edge waits one full word.
//  valid_in while ready_out=0 is ignored. The source holds data_in until it is accepted.
//  Back-to-back: with valid_in held high, words are sent gap-free, one accept per WIDTH cycles.
//  idle_out is registered with each load: 1 for an inserted IDLE_WORD, 0 for user data.
//   A user word equal to IDLE_WORD still gives idle_out=0.
//  frame_start = (cnt==0) && (state!=S_RESET). It is 1 for exactly one cycle per word.
//  Idle insertion and word boundaries are simultaneous on all lanes.
//  The per-lane hold entries are all written together on accept.
//  Reset asserted mid-word takes effect immediately; the sync sequence restarts on release.
// TESTING  (WIDTH=8, LANES=1, MSB_FIRST=1, IDLE_WORD=8'hBC, SYNC_COUNT=4 unless stated)
//  1. Release reset, valid_in=0.
//     -> data_out repeats 1,0,1,1,1,1,0,0; idle_out=1; frame_start every 8th cycle.
//     -> ready_out=0 until the 33rd edge after release, then 1.
//  2. In S_ACTIVE, offer 8'hA5 for one accept mid-word.
//     -> after the next boundary, data_out=1,0,1,0,0,1,0,1 with idle_out=0; then BC resumes with idle_out=1.
//  3. Hold valid_in with 8'h01, 8'h02, 8'h03 (advance on accept).
//     -> 24 consecutive data bits with no idle gap; ready_out stays low between boundaries while hold is full.
//  4. MSB_FIRST=0, send 8'h0F.
//     -> data_out=1,1,1,1,0,0,0,0. With MSB_FIRST=1 the same word gives 0,0,0,0,1,1,1,1.
//  5. LANES=2, data_in=16'h3CC3.
//     -> lane0 sends C3 and lane1 sends 3C in the same cycles; a single frame_start covers both lanes.
//  6. Assert reset mid-word while hold_full=1.
//     -> all outputs go to 0 before the next edge; the held word is never sent.
//     -> after release, 4 idle words are sent before ready_out rises.

Source files
------------

// File: rtl/paralelo_serial_param.sv
// Multi-lane parallel-to-serial transmitter: SYNC_COUNT idle words after reset, then user words or IDLE fill.
// Latency: a word starts after the next boundary edge following its accept (<= WIDTH cycles); ready_out is combinational.

module paralelo_serial_lane #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_word,
  output logic             o_bit
);

  logic [WIDTH-1:0] r_shift;

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      r_shift <= '0;
    end else if (i_load) begin
      r_shift <= i_word;
    end else if (i_shift) begin
      r_shift <= MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
    end
  end

  assign o_bit = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];

endmodule

module paralelo_serial_param #(
  parameter int               WIDTH      = 8,
  parameter int               LANES      = 1,
  parameter bit               MSB_FIRST  = 1'b1,
  parameter logic [WIDTH-1:0] IDLE_WORD  = WIDTH'(8'hBC),
  parameter int               SYNC_COUNT = 4
) (
  input  logic                   clk_32f,
  input  logic                   reset,
  input  logic [WIDTH*LANES-1:0] data_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  output logic [LANES-1:0]       data_out,
  output logic                   frame_start,
  output logic                   idle_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SW = (SYNC_COUNT > 1) ? $clog2(SYNC_COUNT) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);
  localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_COUNT - 1);

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_SYNC   = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CW-1:0]          r_cnt;
  logic [SW-1:0]          r_sync_cnt;
  logic [WIDTH*LANES-1:0] r_hold;
  logic                   r_hold_full;
  logic                   r_idle;

  logic w_boundary;
  logic w_sync_last;
  logic w_accept;
  logic w_load;
  logic w_load_user;
  logic w_shift;

  assign w_boundary  = (r_cnt == CNT_LAST);
  assign w_sync_last = (r_sync_cnt == SYNC_LAST);
  assign w_accept    = valid_in && ready_out;
  // S_RESET loads the first sync word; afterwards every boundary loads a word.
  assign w_load      = (r_state == S_RESET) || w_boundary;
  assign w_load_user = (r_state == S_ACTIVE) && w_boundary && r_hold_full;
  assign w_shift     = (r_state != S_RESET) && !w_boundary;

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RESET:  w_state_nxt = S_SYNC;
      S_SYNC:   if (w_boundary && w_sync_last) w_state_nxt = S_ACTIVE;
      S_ACTIVE: w_state_nxt = S_ACTIVE;
      default:  w_state_nxt = S_RESET;
    endcase
  end

  always_comb begin
    ready_out   = 1'b0;
    frame_start = 1'b0;
    if (r_state == S_ACTIVE) begin
      ready_out = !r_hold_full || w_boundary;
    end
    if (r_state != S_RESET) begin
      frame_start = (r_cnt == '0);
    end
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_sync_cnt <= '0;
    end else if (r_state == S_RESET) begin
      r_cnt      <= '0;
      r_sync_cnt <= '0;
    end else if (w_boundary) begin
      r_cnt <= '0;
      if (r_state == S_SYNC) begin
        r_sync_cnt <= r_sync_cnt + SW'(1);
      end
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // A same-edge accept refills the hold just emptied by the boundary load.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      if (w_load_user) begin
        r_hold_full <= 1'b0;
      end
      if (w_accept) begin
        r_hold      <= data_in;
        r_hold_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      r_idle <= 1'b0;
    end else if (w_load) begin
      r_idle <= !w_load_user;
    end
  end

  assign idle_out = r_idle;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [WIDTH-1:0] w_word;
    assign w_word = w_load_user ? r_hold[k*WIDTH +: WIDTH] : IDLE_WORD;

    paralelo_serial_lane #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
    ) u_lane (
      .clk_32f (clk_32f),
      .reset   (reset),
      .i_load  (w_load),
      .i_shift (w_shift),
      .i_word  (w_word),
      .o_bit   (data_out[k])
    );
  end

endmodule

// File: tb/tb_paralelo_serial_param.sv
// Bench: 2-lane MSB-first DUT against a scoreboard/edge-count model, plus a 1-lane LSB-first DUT.
module tb_paralelo_serial_param;

  localparam int W = 8;
  localparam int L = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [15:0]   din;
  logic          vin;
  logic          rdy;
  logic [L-1:0]  dout;
  logic          fs;
  logic          idl;

  logic [7:0]    din_b;
  logic          vin_b;
  logic          rdy_b;
  logic [0:0]    dout_b;
  logic          fs_b;
  logic          idl_b;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n;
  int last_load_edge = 0;

  typedef struct {
    logic [15:0] d;
    int          acc_edge;
    int          load_edge;
  } exp_t;
  exp_t sb[$];

  logic [15:0] idle_all;
  initial idle_all = {2{8'hBC}};

  paralelo_serial_param #(
    .WIDTH(W), .LANES(L), .MSB_FIRST(1'b1), .IDLE_WORD(8'hBC), .SYNC_COUNT(4)
  ) u_dut (
    .clk_32f(clk), .reset(rst_n), .data_in(din), .valid_in(vin),
    .ready_out(rdy), .data_out(dout), .frame_start(fs), .idle_out(idl)
  );

  paralelo_serial_param #(
    .WIDTH(W), .LANES(1), .MSB_FIRST(1'b0), .IDLE_WORD(8'hBC), .SYNC_COUNT(4)
  ) u_dut_lsb (
    .clk_32f(clk), .reset(rst_n), .data_in(din_b), .valid_in(vin_b),
    .ready_out(rdy_b), .data_out(dout_b), .frame_start(fs_b), .idle_out(idl_b)
  );

  // Edges counted since reset release; edge 1 loads the first sync word.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_cycle(input logic v, input logic [15:0] d, output logic acc);
    int a;
    int r;
    @(negedge clk);
    vin = v;
    din = d;
    #1;
    acc = v && rdy;
    a = edge_n + 1;
    @(posedge clk);
    if (acc) begin
      r = (a - 1) % 8;
      sb.push_back('{d: d, acc_edge: a, load_edge: a - r + 8});
      last_load_edge = a - r + 8;
    end
  endtask

  task automatic send(input logic [15:0] d);
    logic acc;
    int   t;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 40) begin
      drive_cycle(1'b1, d, acc);
      t++;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: per-cycle frame/ready checks and word-level scoreboard compare.
  initial begin
    int          e;
    int          bit_i;
    logic        collecting;
    logic        word_idle;
    int          word_edge;
    logic [15:0] got;
    exp_t        x;
    collecting = 1'b0;
    bit_i = 0;
    word_idle = 1'b0;
    word_edge = 0;
    got = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        collecting = 1'b0;
        check("reset_outputs", {rdy, dout, fs, idl}, 32'd0);
      end else begin
        e = edge_n;
        check("ready_out", rdy, (e >= 33) && !((last_load_edge > e) && (e % 8 != 0)));
        check("frame_start", fs, (e >= 1) && ((e - 1) % 8 == 0));
        if (fs) begin
          collecting = 1'b1;
          bit_i = 0;
          word_idle = idl;
          word_edge = e;
        end
        if (collecting) begin
          check("idle_stable", idl, word_idle);
          for (int k = 0; k < L; k++) got[k*W + (W-1-bit_i)] = dout[k];
          bit_i++;
          if (bit_i == W) begin
            collecting = 1'b0;
            if (word_idle) begin
              check("idle_word", got, idle_all);
              check("data_missed", (sb.size() > 0) && (sb[0].load_edge == word_edge), 32'd0);
            end else if (sb.size() == 0) begin
              check("unexpected_data", got, 32'hDEAD_0000);
            end else begin
              x = sb.pop_front();
              check("data_word", got, x.d);
              check("load_edge", word_edge, x.load_edge);
              check("latency_bound", (word_edge - x.acc_edge) <= 8, 32'd1);
            end
          end
        end
      end
    end
  end

  // LSB-first single-lane DUT: one 8'h0F word must serialise as 1,1,1,1,0,0,0,0.
  initial begin
    int         t;
    logic [7:0] gb;
    vin_b = 1'b0;
    din_b = 8'h00;
    gb = '0;
    @(posedge rst_n);
    t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while (!rdy_b && t < 60);
    check("lsb_ready", rdy_b, 32'd1);
    vin_b = 1'b1;
    din_b = 8'h0F;
    @(posedge clk);
    #1;
    vin_b = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(fs_b && !idl_b) && t < 30);
    check("lsb_word_seen", fs_b && !idl_b, 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      gb[i] = dout_b[0];
    end
    check("lsb_first_bits", gb, 8'h0F);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic        acc;
    logic        pend;
    logic [15:0] pd;
    int          t;
    rst_n = 1'b0;
    vin = 1'b0;
    din = '0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Sync sequence and idle fill with no traffic.
    repeat (50) drive_cycle(1'b0, 16'h0, acc);

    // Single words, including a lane-split pattern and one equal to IDLE.
    send(16'h3CC3);
    repeat (20) drive_cycle(1'b0, 16'h0, acc);
    send(16'hA5A5);
    repeat (20) drive_cycle(1'b0, 16'h0, acc);
    send(16'hBCBC);
    repeat (20) drive_cycle(1'b0, 16'h0, acc);

    // Back-to-back stream with valid held high.
    send(16'h0101);
    send(16'h0202);
    send(16'h0303);
    for (int i = 0; i < 12; i++) send(16'($urandom));
    repeat (20) drive_cycle(1'b0, 16'h0, acc);

    // Random valid gaps; data held until accepted.
    pend = 1'b0;
    pd = '0;
    repeat (300) begin
      if (!pend && $urandom_range(1, 0) == 1) begin
        pend = 1'b1;
        pd = 16'($urandom);
      end
      drive_cycle(pend, pend ? pd : 16'h0, acc);
      if (acc) pend = 1'b0;
    end
    while (pend) begin
      drive_cycle(1'b1, pd, acc);
      if (acc) pend = 1'b0;
    end

    // Reset mid-word with the hold register full.
    t = 0;
    while ((edge_n % 8) != 2 && t < 20) begin
      drive_cycle(1'b0, 16'h0, acc);
      t++;
    end
    send(16'h5AA5);
    check("hold_full_before_reset", last_load_edge > edge_n, 32'd1);
    @(negedge clk);
    vin = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", {rdy, dout, fs, idl}, 32'd0);
    sb.delete();
    last_load_edge = 0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    repeat (40) drive_cycle(1'b0, 16'h0, acc);
    pend = 1'b0;
    repeat (200) begin
      if (!pend && $urandom_range(3, 0) != 0) begin
        pend = 1'b1;
        pd = 16'($urandom);
      end
      drive_cycle(pend, pend ? pd : 16'h0, acc);
      if (acc) pend = 1'b0;
    end
    while (pend) begin
      drive_cycle(1'b1, pd, acc);
      if (acc) pend = 1'b0;
    end

    t = 0;
    while (sb.size() > 0 && t < 100) begin
      drive_cycle(1'b0, 16'h0, acc);
      t++;
    end
    repeat (2) drive_cycle(1'b0, 16'h0, acc);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
